// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - operation codes, FSM states and helpers for seq_alu
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'd0,
        ALU_OR   = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd6,
        ALU_SLT  = 4'd7,
        ALU_MULU = 4'd8,
        ALU_DIVU = 4'd9,
        ALU_NOR  = 4'd12
    } alu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        ITER = 1'b1
    } state_e;

    function automatic logic is_multi(input logic [3:0] op);
        return (op == ALU_MULU) || (op == ALU_DIVU);
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - request/response bundle between execute-stage control and seq_alu
interface seq_alu_if #(
    parameter int W      = 8,
    parameter int CTRL_W = 4
);
    logic              start;
    logic [CTRL_W-1:0] ALU_ctrl;
    logic [W-1:0]      A;
    logic [W-1:0]      B;
    logic              busy;
    logic              done;
    logic [W-1:0]      result;
    logic [W-1:0]      result_hi;
    logic              cout;
    logic              zero;
    logic              div_by_zero;

    modport master (
        output start, ALU_ctrl, A, B,
        input  busy, done, result, result_hi, cout, zero, div_by_zero
    );

    modport slave (
        input  start, ALU_ctrl, A, B,
        output busy, done, result, result_hi, cout, zero, div_by_zero
    );
endinterface

// File: rtl/seq_muldiv_core.sv
// rtl/seq_muldiv_core.sv - W-step shift-add multiplier / restoring divider datapath
module seq_muldiv_core #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         step_i,
    input  logic         is_div_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         last_o,
    output logic [W-1:0] lo_o,
    output logic [W-1:0] hi_o
);
    localparam int CW = $clog2(W + 1);

    logic [CW-1:0] cnt_q;
    logic          div_q;
    logic [W-1:0]  m_q, hi_q, lo_q;
    logic [W-1:0]  hi_d, lo_d;

    logic [W:0]    mul_sum;
    logic [W:0]    shifted;
    logic          ge;
    logic [W-1:0]  sub;

    // multiply: {hi,lo} shifts right, multiplicand added into hi when lo[0] is set
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);

    // divide: remainder in hi, dividend shifts out of lo while quotient bits shift in
    assign shifted = {hi_q, lo_q[W-1]};
    assign ge      = shifted[W] || (shifted[W-1:0] >= m_q);
    assign sub     = shifted[W-1:0] - m_q;

    always_comb begin
        hi_d = mul_sum[W:1];
        lo_d = {mul_sum[0], lo_q[W-1:1]};
        if (div_q) begin
            hi_d = ge ? sub : shifted[W-1:0];
            lo_d = {lo_q[W-2:0], ge};
        end
    end

    assign last_o = (cnt_q == CW'(1));
    assign lo_o   = lo_d;
    assign hi_o   = hi_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            div_q <= 1'b0;
            m_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else if (load_i) begin
            cnt_q <= CW'(W);
            div_q <= is_div_i;
            m_q   <= b_i;
            hi_q  <= '0;
            lo_q  <= a_i;
        end else if (step_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CW'(1);
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end
endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered execute-stage ALU with iterative multiply/divide
module seq_alu
    import alu_pkg::*;
#(
    parameter int W      = 8,
    parameter int CTRL_W = 4
) (
    input  logic     clk,
    input  logic     reset,
    seq_alu_if.slave bus
);
    state_e       state_q;
    logic         busy_q, done_q, cout_q, dbz_q;
    logic [W-1:0] result_q, result_hi_q;

    logic [3:0]   op4;
    logic         op_ok, is_div, div0, go_iter;
    logic [W:0]   sum_w, diff_w;
    logic [W-1:0] sc_res, sc_hi;
    logic         sc_cout, sc_dbz;
    logic         core_last;
    logic [W-1:0] core_lo, core_hi;

    // codes wider than 4 bits with any upper bit set fall through to result 0
    assign op4     = 4'(bus.ALU_ctrl);
    assign op_ok   = ((bus.ALU_ctrl >> 4) == '0);
    assign is_div  = op_ok && (op4 == ALU_DIVU);
    assign div0    = is_div && (bus.B == '0);
    assign go_iter = (state_q == IDLE) && bus.start && op_ok && is_multi(op4) && !div0;

    assign sum_w  = {1'b0, bus.A} + {1'b0, bus.B};
    assign diff_w = {1'b0, bus.A} + {1'b0, ~bus.B} + (W+1)'(1);

    always_comb begin
        sc_res  = '0;
        sc_hi   = '0;
        sc_cout = 1'b0;
        sc_dbz  = 1'b0;
        if (op_ok) begin
            case (op4)
                ALU_AND:  sc_res = bus.A & bus.B;
                ALU_OR:   sc_res = bus.A | bus.B;
                ALU_NOR:  sc_res = ~(bus.A | bus.B);
                ALU_SLT:  sc_res = {{(W-1){1'b0}}, (bus.A < bus.B)};
                ALU_ADD:  {sc_cout, sc_res} = sum_w;
                ALU_SUB:  {sc_cout, sc_res} = diff_w;
                ALU_DIVU: begin
                    sc_res = '1;
                    sc_hi  = bus.A;
                    sc_dbz = 1'b1;
                end
                default: ;
            endcase
        end
    end

    seq_muldiv_core #(.W(W)) u_core (
        .clk      (clk),
        .reset    (reset),
        .load_i   (go_iter),
        .step_i   (state_q == ITER),
        .is_div_i (is_div),
        .a_i      (bus.A),
        .b_i      (bus.B),
        .last_o   (core_last),
        .lo_o     (core_lo),
        .hi_o     (core_hi)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            cout_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (go_iter) begin
                        state_q <= ITER;
                        busy_q  <= 1'b1;
                    end else if (bus.start) begin
                        result_q    <= sc_res;
                        result_hi_q <= sc_hi;
                        cout_q      <= sc_cout;
                        dbz_q       <= sc_dbz;
                        done_q      <= 1'b1;
                    end
                end
                ITER: begin
                    if (core_last) begin
                        result_q    <= core_lo;
                        result_hi_q <= core_hi;
                        cout_q      <= 1'b0;
                        dbz_q       <= 1'b0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.result      = result_q;
    assign bus.result_hi   = result_hi_q;
    assign bus.cout        = cout_q;
    assign bus.zero        = (result_q == '0);
    assign bus.div_by_zero = dbz_q;
endmodule
